// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature step decoder.
// State encoding, error-count ceiling and Gray-phase helper functions.
package qdec_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    S00  = 3'd1,
    S01  = 3'd2,
    S11  = 3'd3,
    S10  = 3'd4
  } qdec_state_t;

  localparam logic [3:0] QDEC_ERR_MAX = 4'd15;

  function automatic logic [1:0] phase_of(input qdec_state_t s);
    logic [1:0] ab;
    case (s)
      S00:     ab = 2'b00;
      S01:     ab = 2'b01;
      S11:     ab = 2'b11;
      S10:     ab = 2'b10;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  function automatic qdec_state_t state_of(input logic [1:0] ab);
    qdec_state_t s;
    case (ab)
      2'b00:   s = S00;
      2'b01:   s = S01;
      2'b11:   s = S11;
      default: s = S10;
    endcase
    return s;
  endfunction

  // Next {A,B} in the forward (up) Gray sequence 00->01->11->10->00.
  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    return {ab[0], ~ab[1]};
  endfunction

endpackage

// File: rtl/qdec_input_filter.sv
// Two-flop synchronizer plus optional stability filter for the A/B pair.
// Filter present only when QDEC_GLITCH_FILTER_EN is defined; otherwise sync output passes through.
module qdec_input_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] filt,
  output logic       filt_valid
);

  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("qdec_input_filter: FILT_LEN must be in 1..15");
  end

  logic [1:0] sync2;
  logic [1:0] prime_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync2[gi] = s2_reg;
    end
  endgenerate

  // Ignore the cleared synchronizer contents until real samples have arrived.
  always_ff @(posedge clk) begin
    if (reset) prime_reg <= 2'b00;
    else       prime_reg <= {prime_reg[0], 1'b1};
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LEN_U4 = 4'(FILT_LEN);

  logic [3:0] cnt_reg, cnt_next;
  logic [1:0] cand_reg, cand_next;
  logic [1:0] filt_reg, filt_next;
  logic       valid_reg, valid_next;

  always_comb begin
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    filt_next  = filt_reg;
    valid_next = valid_reg;
    if (prime_reg[1]) begin
      if (valid_reg && sync2 == filt_reg) begin
        cnt_next = 4'd0;
      end else begin
        // The first qualified value need not differ from the reset value.
        cnt_next  = (cnt_reg != 4'd0 && sync2 == cand_reg) ? cnt_reg + 4'd1 : 4'd1;
        cand_next = sync2;
        if (cnt_next >= FILT_LEN_U4) begin
          filt_next  = sync2;
          valid_next = 1'b1;
          cnt_next   = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= 4'd0;
      cand_reg  <= 2'b00;
      filt_reg  <= 2'b00;
      valid_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
      filt_reg  <= filt_next;
      valid_reg <= valid_next;
    end
  end

  assign filt       = filt_reg;
  assign filt_valid = valid_reg;
`else
  assign filt       = sync2;
  assign filt_valid = prime_reg[1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: Gray-phase FSM producing step/up_down pulses and illegal-jump errors.
// Optional glitch filter in the input path is enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic [1:0] phase
);

  logic [1:0]  filt;
  logic        filt_valid;
  qdec_state_t state_reg, state_next;
  logic        step_reg, step_next;
  logic        up_reg, up_next;
  logic        err_reg, err_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  cur_ab;
  logic        decoding, move_fwd, move_rev, illegal;

  qdec_input_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .raw        ({a_in, b_in}),
    .filt       (filt),
    .filt_valid (filt_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      step_reg  <= 1'b0;
      up_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      up_reg    <= up_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Every decoded sample, legal or not, is adopted as the new state.
  always_comb begin
    state_next = state_reg;
    if (filt_valid) state_next = state_of(filt);
  end

  assign cur_ab   = phase_of(state_reg);
  assign decoding = filt_valid && (state_reg != INIT);
  assign move_fwd = decoding && (filt == next_fwd(cur_ab));
  assign move_rev = decoding && (cur_ab == next_fwd(filt));
  assign illegal  = decoding && (filt == ~cur_ab);

  always_comb begin
    step_next = move_fwd || move_rev;
    up_next   = up_reg;
    err_next  = err_reg;
    cnt_next  = cnt_reg;
    if (move_fwd)      up_next = 1'b1;
    else if (move_rev) up_next = 1'b0;
    // A new illegal jump wins over a simultaneous clear.
    if (illegal) begin
      err_next = 1'b1;
      if (err_clr)                    cnt_next = 4'd1;
      else if (cnt_reg != QDEC_ERR_MAX) cnt_next = cnt_reg + 4'd1;
    end else if (err_clr) begin
      err_next = 1'b0;
      cnt_next = 4'd0;
    end
  end

  assign step    = step_reg;
  assign up_down = up_reg;
  assign err     = err_reg;
  assign err_cnt = cnt_reg;
  assign phase   = phase_of(state_reg);

endmodule
